aes_result_monitor: RTL and testbench

- Downstream consumer of the pipelined aes_128 core in the randomized AES test harness.
- Gates how many state/key vectors the LFSR stimulus issues, and tracks each issued vector through the fixed AES pipeline latency.
- Captures every resulting ciphertext and compresses the results into a 128-bit MISR signature.
- Raises done once exactly num_tests results are collected, so that regressions compare one signature instead of full traces.

---
 rtl/aes_result_monitor.sv | 111 +++++++++++
 tb/tb_aes_result_monitor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/aes_result_monitor.sv
// Result monitor for the pipelined AES core: gates issues, tracks each through the fixed
// pipeline latency, captures ciphertexts and folds them into a MISR signature.
module aes_result_monitor #(
    parameter int                     NUM_BITS    = 128,
    parameter int                     AES_LATENCY = 21,
    parameter logic [NUM_BITS-1:0]    MISR_SEED   = NUM_BITS'(1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [31:0]         num_tests,
    input  logic                in_valid,
    output logic                issue_en,
    input  logic [NUM_BITS-1:0] aes_out,
    output logic                out_valid,
    output logic [NUM_BITS-1:0] out_data,
    output logic [NUM_BITS-1:0] misr_sig,
    output logic [31:0]         result_count,
    output logic                busy,
    output logic                done
);

    // Handshake: an issue occurs on any edge where in_valid & issue_en; in_valid alone is ignored.
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [31:0]            issued_count;
    logic [31:0]            num_tests_q;
    logic [AES_LATENCY-1:0] tag_line;
    logic                   issue;
    logic                   capture;
    logic                   accept_start;
    logic                   misr_fb;

    assign accept_start = start && (state == IDLE || state == DONE);
    assign issue        = in_valid && issue_en;
    assign capture      = tag_line[AES_LATENCY-1];
    assign busy         = (state == RUN) || (state == DRAIN);
    assign done         = (state == DONE);
    assign misr_fb      = misr_sig[127] ^ misr_sig[125] ^ misr_sig[100] ^ misr_sig[98];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue_en   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (num_tests == 32'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                issue_en = (issued_count < num_tests_q);
                if (issue && (issued_count + 32'd1 == num_tests_q)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (capture && (result_count + 32'd1 == num_tests_q)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issued_count <= 32'd0;
            num_tests_q  <= 32'd0;
            tag_line     <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            misr_sig     <= MISR_SEED;
            result_count <= 32'd0;
        end else begin
            out_valid <= 1'b0;
            if (accept_start) begin
                num_tests_q  <= num_tests;
                issued_count <= 32'd0;
                result_count <= 32'd0;
                tag_line     <= '0;
                misr_sig     <= MISR_SEED;
            end else begin
                // Tag shifts one stage per edge; the tag leaving the last stage marks a valid aes_out.
                tag_line[0] <= issue;
                for (int i = 1; i < AES_LATENCY; i++) begin
                    tag_line[i] <= tag_line[i-1];
                end
                if (issue) begin
                    issued_count <= issued_count + 32'd1;
                end
                if (capture) begin
                    out_data     <= aes_out;
                    out_valid    <= 1'b1;
                    result_count <= result_count + 32'd1;
                    misr_sig     <= {misr_sig[NUM_BITS-2:0], misr_fb} ^ aes_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_result_monitor.sv
// Directed/randomized bench for aes_result_monitor against a queue-based reference model.
module tb_aes_result_monitor;

    localparam int          LAT  = 21;
    localparam logic [127:0] SEED = 128'h1;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [31:0]  num_tests;
    logic         in_valid;
    logic         issue_en;
    logic [127:0] aes_out;
    logic         out_valid;
    logic [127:0] out_data;
    logic [127:0] misr_sig;
    logic [31:0]  result_count;
    logic         busy;
    logic         done;

    aes_result_monitor #(.NUM_BITS(128), .AES_LATENCY(LAT), .MISR_SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_tests(num_tests),
        .in_valid(in_valid), .issue_en(issue_en), .aes_out(aes_out),
        .out_valid(out_valid), .out_data(out_data), .misr_sig(misr_sig),
        .result_count(result_count), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int           n_vec = 0;
    int           n_err = 0;
    int           cyc   = 0;
    int           due_q[$];
    logic [127:0] exp_data;
    logic [127:0] exp_sig;
    logic         exp_valid;
    int           exp_cnt;
    int           m_issued;
    int           m_num;
    bit           m_busy;
    bit           m_done;
    bit           aes_fixed_mode;
    logic [127:0] aes_fixed_val;
    int           dut_pulses;
    int           dut_issues;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] misr_next(input logic [127:0] s, input logic [127:0] d);
        logic fb;
        fb = s[127] ^ s[125] ^ s[100] ^ s[98];
        return {s[126:0], fb} ^ d;
    endfunction

    // One clock: check issue_en before the edge, update the model, check outputs #1 after.
    task automatic step();
        logic exp_issue_en;
        aes_out = aes_fixed_mode ? aes_fixed_val : {$urandom, $urandom, $urandom, $urandom};
        #1;
        exp_issue_en = m_busy && (m_issued < m_num);
        check("issue_en", {127'd0, issue_en}, {127'd0, exp_issue_en});
        if (in_valid && issue_en) dut_issues++;
        @(posedge clk);
        cyc++;
        exp_valid = 1'b0;
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_issued = 0; m_num = 0; exp_cnt = 0;
            exp_sig = SEED; exp_data = '0; due_q.delete();
        end else if (start && !m_busy) begin
            m_num = int'(num_tests); m_issued = 0; exp_cnt = 0; exp_sig = SEED; due_q.delete();
            m_busy = (m_num != 0);
            m_done = (m_num == 0);
        end else begin
            if (in_valid && exp_issue_en) begin
                m_issued++;
                due_q.push_back(cyc + LAT);
            end
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                exp_valid = 1'b1;
                exp_data  = aes_out;
                exp_sig   = misr_next(exp_sig, aes_out);
                exp_cnt++;
                if (exp_cnt == m_num) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
        #1;
        check("out_valid", {127'd0, out_valid}, {127'd0, exp_valid});
        check("out_data", out_data, exp_data);
        check("misr_sig", misr_sig, exp_sig);
        check("result_count", {96'd0, result_count}, 128'(exp_cnt));
        check("busy", {127'd0, busy}, {127'd0, m_busy});
        check("done", {127'd0, done}, {127'd0, m_done});
        if (out_valid) dut_pulses++;
    endtask

    // pat: 0 = in_valid always high, 1 = every other cycle, 2 = random.
    task automatic run_test(input int n, input int pat, input bit fixed, input logic [127:0] val,
                            input bit poke);
        int k;
        aes_fixed_mode = fixed;
        aes_fixed_val  = val;
        dut_pulses = 0;
        dut_issues = 0;
        start = 1'b1; num_tests = 32'(n); in_valid = 1'b0;
        step();
        start = 1'b0; num_tests = $urandom;
        k = 0;
        while (!m_done && k < 400) begin
            case (pat)
                0:       in_valid = 1'b1;
                1:       in_valid = k[0];
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            if (poke && k == 3) begin
                start = 1'b1; num_tests = 32'd7;
            end else begin
                start = 1'b0;
            end
            step();
            k++;
        end
        start = 1'b0;
        check("run_finished", {127'd0, m_done}, 128'd1);
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        check("issue_total", 128'(dut_issues), 128'(n));
        check("pulse_total", 128'(dut_pulses), 128'(n));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_tests = '0; in_valid = 1'b0; aes_out = '0;
        aes_fixed_mode = 1'b0; aes_fixed_val = '0;
        m_busy = 0; m_done = 0; m_issued = 0; m_num = 0; exp_cnt = 0;
        exp_sig = SEED; exp_data = '0; exp_valid = 1'b0;
        dut_pulses = 0; dut_issues = 0;

        repeat (2) step();
        rst_n = 1'b1;
        step();

        run_test(1, 0, 1'b0, '0, 1'b0);

        run_test(1, 0, 1'b1, 128'h0, 1'b0);
        check("misr_one_zero", misr_sig, 128'h2);
        run_test(2, 0, 1'b1, 128'h0, 1'b0);
        check("misr_two_zero", misr_sig, 128'h4);
        run_test(1, 0, 1'b1, 128'hFF, 1'b0);
        check("misr_ff", misr_sig, 128'hFD);

        run_test(5, 1, 1'b0, '0, 1'b1);

        run_test(0, 0, 1'b0, '0, 1'b0);
        check("zero_count", {96'd0, result_count}, 128'd0);
        check("zero_sig", misr_sig, SEED);

        run_test(20, 2, 1'b0, '0, 1'b0);

        aes_fixed_mode = 1'b0;
        start = 1'b1; num_tests = 32'd4; in_valid = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10 && m_issued < 4; i++) step();
        repeat (3) step();
        check("in_drain", {127'd0, busy}, 128'd1);
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        dut_pulses = 0;
        repeat (30) step();
        check("no_pulse_after_reset", 128'(dut_pulses), 128'd0);
        run_test(2, 0, 1'b0, '0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
